// File: rtl/logs_pkg.sv
// Shared definitions for the logistic-map column collector.
package logs_pkg;

  // Default fraction width of x; r is carried as 2.FRAC fixed point.
  localparam int LOGS_FRAC = 4;
  localparam int R_W       = LOGS_FRAC + 2;
  localparam int BINS      = 1 << LOGS_FRAC;

  // Sweep controller states.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_COLLECT = 2'd2,
    S_HOLD    = 2'd3
  } logs_state_e;

endpackage

// File: rtl/logs_bin_accum.sv
// Visited-bin bitmap: one bit per x value, cleared between columns and
// OR-accumulated while a column is being collected.
module logs_bin_accum
  import logs_pkg::*;
#(
  parameter int FRAC = LOGS_FRAC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_set,
  input  logic [FRAC-1:0]        i_idx,
  output logic [(1<<FRAC)-1:0]   o_bitmap
);

  localparam int NB = 1 << FRAC;

  logic [NB-1:0] w_onehot;
  logic [NB-1:0] r_bits;

  // One-hot decode of the incoming bin index.
  for (genvar k = 0; k < NB; k++) begin : g_dec
    assign w_onehot[k] = (i_idx == FRAC'(k));
  end

  // Clear wins over set; bits are only ever added during a column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_bits <= '0;
    else if (i_clr) r_bits <= '0;
    else if (i_set) r_bits <= r_bits | w_onehot;
  end

  assign o_bitmap = r_bits;

endmodule

// File: rtl/logs_column_collector.sv
// Sweeps r across [R_MIN, R_MAX], discards transient iterations per r,
// records visited x bins as a bitmap and hands each column downstream
// through a valid/ack handshake.
module logs_column_collector
  import logs_pkg::*;
#(
  parameter int               FRAC    = LOGS_FRAC,
  parameter int               SETTLE  = 16,
  parameter int               SAMPLES = 32,
  parameter logic [FRAC+1:0]  R_MIN   = 6'h30,
  parameter logic [FRAC+1:0]  R_STEP  = 6'h04,
  parameter logic [FRAC+1:0]  R_MAX   = 6'h3C
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAC-1:0]       x,
  input  logic                  next_ready,
  output logic [FRAC+1:0]       r,
  output logic                  busy,
  output logic                  col_valid,
  output logic [(1<<FRAC)-1:0]  col_bitmap,
  input  logic                  col_ack,
  output logic                  sweep_done
);

  localparam int CNT_MAX  = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int SET_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam int SMP_LAST = (SAMPLES > 0) ? SAMPLES - 1 : 0;

  logs_state_e       r_state;
  logic [CW-1:0]     r_cnt;
  logic [FRAC+1:0]   r_rval;
  logic              r_busy;
  logic              r_valid;
  logic              r_done;

  logic [FRAC+2:0]   w_r_sum;
  logic              w_last;
  logic              w_clr;
  logic              w_set;

  // One extra bit so r+R_STEP cannot wrap before the end-of-sweep test.
  assign w_r_sum = {1'b0, r_rval} + {1'b0, R_STEP};
  assign w_last  = (w_r_sum > {1'b0, R_MAX});

  // Bitmap control: clear on sweep start and on each advance to a new r,
  // set only for samples taken while collecting.
  always_comb begin
    w_clr = 1'b0;
    w_set = 1'b0;
    case (r_state)
      S_IDLE:    w_clr = start;
      S_COLLECT: w_set = next_ready;
      S_HOLD:    w_clr = col_ack && !w_last;
      default:   ;
    endcase
  end

  logs_bin_accum #(.FRAC(FRAC)) u_bins (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_set    (w_set),
    .i_idx    (x),
    .o_bitmap (col_bitmap)
  );

  // Sweep FSM with counter, r stepping and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rval  <= R_MIN;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rval  <= R_MIN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= (SETTLE == 0) ? S_COLLECT : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (next_ready) begin
            if (r_cnt == CW'(SET_LAST)) begin
              r_cnt   <= '0;
              r_state <= S_COLLECT;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_COLLECT: begin
          if (next_ready) begin
            if (r_cnt == CW'(SMP_LAST)) begin
              r_cnt   <= '0;
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_HOLD: begin
          if (col_ack) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_rval  <= w_r_sum[FRAC+1:0];
              r_state <= (SETTLE == 0) ? S_COLLECT : S_SETTLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign r          = r_rval;
  assign busy       = r_busy;
  assign col_valid  = r_valid;
  assign sweep_done = r_done;

endmodule

// File: tb/tb_logs_column_collector.sv
// Directed + randomized bench for the column collector. A second instance
// with SETTLE=0, R_STEP=5 exercises the non-exact sweep end.
module tb_logs_column_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  x;
  logic        next_ready;
  logic        start_a, ack_a, start_b, ack_b;

  logic [5:0]  r_a, r_b;
  logic        busy_a, busy_b, cv_a, cv_b, sd_a, sd_b;
  logic [15:0] bm_a, bm_b;

  int errors = 0;
  int checks = 0;
  int vcnt   = 0;
  logic cv_prev = 1'b0;

  logs_column_collector u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .x(x), .next_ready(next_ready),
    .r(r_a), .busy(busy_a), .col_valid(cv_a), .col_bitmap(bm_a),
    .col_ack(ack_a), .sweep_done(sd_a)
  );

  logs_column_collector #(
    .FRAC(4), .SETTLE(0), .SAMPLES(3),
    .R_MIN(6'h30), .R_STEP(6'h05), .R_MAX(6'h3C)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .x(x), .next_ready(next_ready),
    .r(r_b), .busy(busy_b), .col_valid(cv_b), .col_bitmap(bm_b),
    .col_ack(ack_b), .sweep_done(sd_b)
  );

  // Count completed-column events on instance A.
  always @(posedge clk) begin
    cv_prev <= cv_a;
    if (cv_a && !cv_prev) vcnt <= vcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Two idle cycles, then one next_ready cycle; returns just after the
  // edge that sampled the pulse.
  task automatic pulse(input logic [3:0] v, input logic st, input logic ak);
    tick(2);
    x = v; next_ready = 1'b1; start_a = st; ack_a = ak;
    tick(1);
    next_ready = 1'b0; start_a = 1'b0; ack_a = 1'b0;
  endtask

  // One column on instance A (16 discarded + 32 recorded pulses).
  task automatic col_a(input bit rnd, input logic [3:0] sx, input logic [3:0] cx,
                       input int start_at, input int ack_at, input logic [5:0] er,
                       output logic [15:0] exp);
    exp = '0;
    for (int i = 0; i < 48; i++) begin
      logic [3:0] v;
      if (rnd) v = 4'($urandom_range(0, 15));
      else     v = (i < 16) ? sx : cx;
      if (i >= 16) exp = exp | (16'd1 << v);
      if (i == 20) chk("r_const", r_a, er);
      if (i == 47) chk("valid_early", cv_a, 1'b0);
      pulse(v, i == start_at, i == ack_at);
    end
    chk("valid_rise", cv_a, 1'b1);
  endtask

  task automatic do_ack_a();
    ack_a = 1'b1; tick(1); ack_a = 1'b0;
  endtask

  initial begin
    logic [15:0] exp;
    logic [5:0]  er;
    int          ncol;

    rst_n = 1'b0; x = '0; next_ready = 1'b0;
    start_a = 1'b0; ack_a = 1'b0; start_b = 1'b0; ack_b = 1'b0;
    tick(2);
    chk("rst_r",     r_a,  6'h30);
    chk("rst_busy",  busy_a, 1'b0);
    chk("rst_valid", cv_a, 1'b0);
    chk("rst_bm",    bm_a, 16'h0);
    chk("rst_done",  sd_a, 1'b0);
    chk("rst_r_b",   r_b,  6'h30);
    rst_n = 1'b1;
    tick(1);

    // Column 1: settle with x=3, collect x=9, start pulsed mid-collect.
    start_a = 1'b1; tick(1); start_a = 1'b0;
    chk("busy_start", busy_a, 1'b1);
    col_a(1'b0, 4'd3, 4'd9, 30, -1, 6'h30, exp);
    chk("col1_bm_model", bm_a, exp);
    chk("col1_bm_const", bm_a, 16'h0200);

    // Downstream stalls ~100 cycles while iterations keep arriving.
    for (int i = 0; i < 34; i++) pulse(4'($urandom_range(0, 15)), 1'b0, 1'b0);
    chk("stall_valid", cv_a, 1'b1);
    chk("stall_bm",    bm_a, 16'h0200);
    chk("stall_r",     r_a,  6'h30);
    do_ack_a();
    chk("ack_valid", cv_a, 1'b0);
    chk("ack_bm",    bm_a, 16'h0);
    chk("ack_r",     r_a,  6'h34);

    // Remaining columns with random x; an ack in SETTLE must be ignored.
    er = 6'h34;
    for (int k = 1; k < 4; k++) begin
      col_a(1'b1, 4'd0, 4'd0, -1, (k == 1) ? 3 : -1, er, exp);
      chk("colk_bm", bm_a, exp);
      chk("colk_r",  r_a,  er);
      do_ack_a();
      if (7'(er) + 7'h04 > 7'h3C) begin
        chk("end_done",  sd_a,   1'b1);
        chk("end_busy",  busy_a, 1'b0);
        chk("end_valid", cv_a,   1'b0);
        tick(1);
        chk("done_pulse", sd_a, 1'b0);
      end else begin
        er = er + 6'h04;
        chk("next_r", r_a, er);
      end
    end
    chk("valid_events", vcnt, 4);
    chk("idle_busy", busy_a, 1'b0);

    // Instance B: SETTLE=0, 3 samples, step 5 -> 0x30, 0x35, 0x3A.
    start_b = 1'b1; tick(1); start_b = 1'b0;
    er = 6'h30; ncol = 0;
    for (int k = 0; k < 8; k++) begin
      exp = '0;
      for (int i = 0; i < 3; i++) begin
        logic [3:0] v;
        v = 4'($urandom_range(0, 15));
        exp = exp | (16'd1 << v);
        pulse(v, 1'b0, 1'b0);
      end
      ncol++;
      chk("b_valid", cv_b, 1'b1);
      chk("b_bm",    bm_b, exp);
      chk("b_r",     r_b,  er);
      ack_b = 1'b1; tick(1); ack_b = 1'b0;
      if (7'(er) + 7'h05 > 7'h3C) begin
        chk("b_done", sd_b,   1'b1);
        chk("b_busy", busy_b, 1'b0);
        break;
      end
      er = er + 6'h05;
      chk("b_next_r", r_b, er);
    end
    chk("b_cols", ncol, 3);

    // Reset mid-COLLECT of column 2 on A.
    start_a = 1'b1; tick(1); start_a = 1'b0;
    col_a(1'b1, 4'd0, 4'd0, -1, -1, 6'h30, exp);
    do_ack_a();
    for (int i = 0; i < 21; i++) pulse(4'($urandom_range(0, 15)), 1'b0, 1'b0);
    chk("pre_rst_r", r_a, 6'h34);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_r",     r_a,    6'h30);
    chk("arst_busy",  busy_a, 1'b0);
    chk("arst_valid", cv_a,   1'b0);
    chk("arst_bm",    bm_a,   16'h0);
    chk("arst_done",  sd_a,   1'b0);
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) pulse(4'd7, 1'b0, 1'b0);
    chk("post_rst_valid", cv_a, 1'b0);
    chk("post_rst_bm",    bm_a, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
